// File: rtl/output_arbiter_if.sv
// Output-link bundle between an output_arbiter and its input FIFOs / downstream link.
// slave: arbiter side; master: FIFO/link (or bench) side.
interface output_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
);
  localparam int N        = PORTS_NUM + 1;
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;

  logic [N-1:0]          req_i;
  logic [N*BUS_SIZE-1:0] data_i;
  logic                  out_full_i;
  logic [N-1:0]          rd_o;
  logic                  out_wr_o;
  logic [BUS_SIZE-1:0]   out_data_o;
  logic [N-1:0]          grant_o;
  logic                  err_o;

  modport slave (
    input  req_i, data_i, out_full_i,
    output rd_o, out_wr_o, out_data_o,
    output grant_o, err_o
  );

  modport master (
    output req_i, data_i, out_full_i,
    input  rd_o, out_wr_o, out_data_o,
    input  grant_o, err_o
  );
endinterface

// File: rtl/output_arbiter.sv
// Packet-granular (wormhole) round-robin arbiter for one switch output link.
// Ports: clk, a_rst_n (async, active low), bus (output_arbiter_if.slave):
//   req_i/data_i/out_full_i in; rd_o (comb pop), out_wr_o/out_data_o/grant_o/err_o registered.
// Optional: define ARB_TIMEOUT_EN for a watchdog that drops a lock whose owner stops requesting.
module output_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int TIMEOUT_W = 8
) (
  input logic              clk,
  input logic              a_rst_n,
  output_arbiter_if.slave  bus
);
  localparam int N        = PORTS_NUM + 1;
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int IW       = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       last_q, last_d;
  logic [IW-1:0]       sel;
  logic [N-1:0]        grant_q, grant_d;
  logic                found;
  logic [BUS_SIZE-1:0] head;
  logic                xfer;
  logic                tail;
  logic                tmo;
  logic                wr_q;
  logic [BUS_SIZE-1:0] data_q;

  // Search starts just above the last winner and wraps,
  // so the previous owner has lowest priority.
  always_comb begin
    int k;
    k     = 0;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last_q) + i) % N;
      if (!found && bus.req_i[k]) begin
        found = 1'b1;
        sel   = IW'(k);
      end
    end
  end

  assign head = bus.data_i[gidx_q*BUS_SIZE +: BUS_SIZE];
  assign tail = head[ADDR_SIZE];
  assign xfer = (state_q == BUSY)
              && bus.req_i[gidx_q]
              && !bus.out_full_i;

  assign bus.rd_o = xfer ? (N'(1) << gidx_q) : '0;

`ifdef ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 err_q;

  assign cnt_inc = cnt_q + 1'b1;

  // Counts only cycles where the owner has nothing to offer;
  // downstream stalls leave it untouched.
  always_comb begin
    cnt_d = cnt_q;
    tmo   = 1'b0;
    if (state_q != BUSY || xfer) begin
      cnt_d = '0;
    end else if (!bus.req_i[gidx_q]) begin
      tmo   = &cnt_inc;
      cnt_d = tmo ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= tmo;
    end
  end

  assign bus.err_o = err_q;
`else
  // No watchdog: the lock is held until the tail flit.
  assign tmo       = 1'b0;
  assign bus.err_o = (TIMEOUT_W < 0);
`endif

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gidx_d  = sel;
          grant_d = N'(1) << sel;
        end
      end
      BUSY: begin
        if ((xfer && tail) || tmo) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(PORTS_NUM);
      grant_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_q    <= xfer;
      if (xfer) data_q <= head;
    end
  end

  assign bus.out_wr_o   = wr_q;
  assign bus.out_data_o = data_q;
  assign bus.grant_o    = grant_q;

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter: per-port packet sources,
// transaction-level reference model, directed scenarios plus random traffic.
module tb_output_arbiter;
  localparam int DS = 32;
  localparam int AS = 4;
  localparam int PN = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = 3;
`else
  localparam int TW = 8;
`endif
  localparam int N  = PN + 1;
  localparam int B  = DS + AS + 1;
  localparam int MAXT = (1 << TW) - 1;

  logic clk = 1'b0;
  logic a_rst_n;
  always #5 clk = ~clk;

  output_arbiter_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN)) bus ();

  output_arbiter #(
    .DATA_SIZE(DS), .ADDR_SIZE(AS), .PORTS_NUM(PN), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus)
  );

  logic [B-1:0] srcq [N][$];
  logic [N-1:0] drop;
  logic         full;

  int           own, last, mcnt;
  logic         m_wr, m_err;
  logic [B-1:0] m_data;

  int           errors = 0;
  int           checks = 0;
  int           glog[$];
  logic [N-1:0] prev_grant;
  logic [N-1:0] obs_rd;

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [B-1:0] mkflit(
    input logic [AS-1:0] a, input logic t, input logic [DS-1:0] pl);
    return {pl, t, a};
  endfunction

  function automatic bit pending();
    bit p;
    p = (own >= 0);
    for (int i = 0; i < N; i++)
      if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic push_pkt(input int p, input int len);
    for (int i = 0; i < len; i++)
      srcq[p].push_back(mkflit(AS'($urandom), (i == len - 1), $urandom));
  endtask

  task automatic model_reset();
    own = -1; last = PN; mcnt = 0;
    m_wr = 1'b0; m_err = 1'b0; m_data = '0;
    prev_grant = '0;
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      bus.req_i[p] = (srcq[p].size() > 0) && !drop[p];
      bus.data_i[p*B +: B] = (srcq[p].size() > 0) ? srcq[p][0] : '0;
    end
    bus.out_full_i = full;
  endtask

  // One clock: drive, compare the pop strobe, advance the model,
  // compare registered outputs just after the edge.
  task automatic cycle();
    logic [N-1:0] r, erd;
    logic         f, t;
    int           gi;
    drive();
    #2;
    r = bus.req_i;
    f = full;
    erd = (own >= 0 && r[own] && !f) ? oh(own) : '0;
    obs_rd = bus.rd_o;
    checks++;
    if (bus.rd_o !== erd)
      $display("FAIL rd got=%b exp=%b t=%0t", bus.rd_o, erd, $time);
    if (bus.rd_o !== erd) errors++;
    checks++;
    if (!$onehot0(bus.rd_o)) begin
      errors++;
      $display("FAIL rd_onehot got=%b exp=onehot0", bus.rd_o);
    end
    m_err = 1'b0;
    if (own < 0) begin
      m_wr = 1'b0;
      mcnt = 0;
      for (int i = 1; i <= N; i++) begin
        int k = (last + i) % N;
        if (r[k]) begin own = k; break; end
      end
    end else if (erd != '0) begin
      m_wr = 1'b1;
      m_data = srcq[own].pop_front();
      mcnt = 0;
      t = m_data[AS];
      if (t) begin last = own; own = -1; end
    end else begin
      m_wr = 1'b0;
      if (!r[own]) begin
        mcnt++;
`ifdef ARB_TIMEOUT_EN
        if (mcnt == MAXT) begin
          m_err = 1'b1; last = own; own = -1; mcnt = 0;
        end
`endif
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.grant_o !== oh(own)) begin
      errors++;
      $display("FAIL grant got=%b exp=%b t=%0t", bus.grant_o, oh(own), $time);
    end
    checks++;
    if (bus.out_wr_o !== m_wr) begin
      errors++;
      $display("FAIL out_wr got=%b exp=%b t=%0t", bus.out_wr_o, m_wr, $time);
    end
    checks++;
    if (bus.out_data_o !== m_data) begin
      errors++;
      $display("FAIL out_data got=%h exp=%h t=%0t", bus.out_data_o, m_data, $time);
    end
    checks++;
    if (bus.err_o !== m_err) begin
      errors++;
      $display("FAIL err got=%b exp=%b t=%0t", bus.err_o, m_err, $time);
    end
    if (bus.grant_o != '0 && prev_grant == '0) begin
      gi = -1;
      for (int i = 0; i < N; i++) if (bus.grant_o[i]) gi = i;
      glog.push_back(gi);
    end
    prev_grant = bus.grant_o;
  endtask

  task automatic drain(input int maxc, output int n);
    n = 0;
    while (pending() && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL drain_timeout got=%0d cycles exp=idle", n);
    end
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0;
    drop = '0;
    full = 1'b0;
    model_reset();
    drive();
    #12;
    checks++;
    if (bus.grant_o !== '0) begin
      errors++; $display("FAIL rst_grant got=%b exp=0", bus.grant_o);
    end
    checks++;
    if (bus.out_wr_o !== 1'b0) begin
      errors++; $display("FAIL rst_wr got=%b exp=0", bus.out_wr_o);
    end
    checks++;
    if (bus.out_data_o !== '0) begin
      errors++; $display("FAIL rst_data got=%h exp=0", bus.out_data_o);
    end
    checks++;
    if (bus.rd_o !== '0 || bus.err_o !== 1'b0) begin
      errors++; $display("FAIL rst_rd_err got=%b/%b exp=0/0", bus.rd_o, bus.err_o);
    end
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [B-1:0] f;
    f = mkflit(4'h3, 1'b1, 32'hA5A5A5A5);
    srcq[2].push_back(f);
    cycle();
    checks++;
    if (bus.grant_o !== 5'b00100) begin
      errors++; $display("FAIL single_grant got=%b exp=00100", bus.grant_o);
    end
    cycle();
    checks++;
    if (obs_rd !== 5'b00100) begin
      errors++; $display("FAIL single_rd got=%b exp=00100", obs_rd);
    end
    checks++;
    if (bus.out_wr_o !== 1'b1 || bus.out_data_o !== f) begin
      errors++;
      $display("FAIL single_out got=%b/%h exp=1/%h", bus.out_wr_o, bus.out_data_o, f);
    end
    checks++;
    if (bus.grant_o !== '0) begin
      errors++; $display("FAIL single_idle got=%b exp=0", bus.grant_o);
    end
    cycle();
    checks++;
    if (bus.out_wr_o !== 1'b0) begin
      errors++; $display("FAIL single_wr_drop got=%b exp=0", bus.out_wr_o);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};
    a_rst_n = 1'b0;
    model_reset();
    #2;
    a_rst_n = 1'b1;
    for (int p = 0; p < N; p++) begin
      push_pkt(p, 2);
      push_pkt(p, 2);
    end
    glog.delete();
    drain(200, n);
    checks++;
    if (n != 30) begin
      errors++; $display("FAIL rr_cycles got=%0d exp=30", n);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (glog.size() <= i || glog[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d] got=%0d exp=%0d", i,
                 (glog.size() > i) ? glog[i] : -1, exp_order[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    push_pkt(1, 3);
    cycle();
    cycle();
    full = 1'b1;
    repeat (4) begin
      cycle();
      checks++;
      if (obs_rd !== '0 || bus.out_wr_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall got=%b/%b exp=0/0", obs_rd, bus.out_wr_o);
      end
      checks++;
      if (bus.grant_o !== 5'b00010) begin
        errors++; $display("FAIL bp_grant got=%b exp=00010", bus.grant_o);
      end
    end
    full = 1'b0;
    drain(20, n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL bp_rest got=%0d cycles exp=2", n);
    end
  endtask

  task automatic test_lock_hold();
    int n;
    push_pkt(0, 4);
    cycle();
    cycle();
    drop[0] = 1'b1;
    push_pkt(3, 1);
    repeat (5) begin
      cycle();
      checks++;
      if (bus.grant_o !== 5'b00001) begin
        errors++; $display("FAIL lock_grant got=%b exp=00001", bus.grant_o);
      end
    end
    drop[0] = 1'b0;
    glog.delete();
    drain(40, n);
    checks++;
    if (glog.size() < 1 || glog[0] != 3) begin
      errors++;
      $display("FAIL lock_next got=%0d exp=3", (glog.size() > 0) ? glog[0] : -1);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    push_pkt(0, 4);
    push_pkt(2, 2);
    cycle();
    cycle();
    cycle();
    drive();
    #2;
    a_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_o !== '0 || bus.out_wr_o !== 1'b0) begin
      errors++;
      $display("FAIL mrst_rd_wr got=%b/%b exp=0/0", bus.rd_o, bus.out_wr_o);
    end
    checks++;
    if (bus.grant_o !== '0 || bus.out_data_o !== '0) begin
      errors++;
      $display("FAIL mrst_grant_data got=%b/%h exp=0/0", bus.grant_o, bus.out_data_o);
    end
    model_reset();
    srcq[2].delete();
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    cycle();
    checks++;
    if (bus.grant_o !== 5'b00001) begin
      errors++; $display("FAIL mrst_regrant got=%b exp=00001", bus.grant_o);
    end
    drain(20, n);
  endtask

  task automatic test_random();
    int n;
    repeat (400) begin
      for (int p = 0; p < N; p++) begin
        if (srcq[p].size() == 0 && $urandom_range(3) == 0)
          push_pkt(p, 1 + $urandom_range(3));
        drop[p] = ($urandom_range(9) == 0);
      end
      full = ($urandom_range(3) == 0);
      cycle();
    end
    drop = '0;
    full = 1'b0;
    drain(500, n);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int pulses;
    int n;
    pulses = 0;
    push_pkt(2, 2);
    cycle();
    drop[2] = 1'b1;
    repeat (MAXT + 1) begin
      cycle();
      if (bus.err_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL tmo_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (bus.grant_o !== '0) begin
      errors++; $display("FAIL tmo_grant got=%b exp=0", bus.grant_o);
    end
    drop[2] = 1'b0;
    push_pkt(4, 1);
    glog.delete();
    drain(40, n);
    checks++;
    if (glog.size() < 1 || glog[0] != 4) begin
      errors++;
      $display("FAIL tmo_next got=%0d exp=4", (glog.size() > 0) ? glog[0] : -1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lock_hold();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one switch output link between the PORTS_NUM+1 input FIFOs of a switch.
- Wormhole style: once a port is granted, the lock holds until that port's tail flit has been transferred.
- Sits between the per-input FIFOs (read side) and the output link/next-hop FIFO (write side). It pops one flit per transfer and forwards it through a registered output.

Parameters:
- DATA_SIZE, 32, payload width per flit.
- ADDR_SIZE, 4, destination address width.
- PORTS_NUM, 4, number of neighbour ports; requesters = PORTS_NUM+1 (the extra one is the local port).
- TIMEOUT_W, 8, watchdog counter width; used only with ARB_TIMEOUT_EN.
- BUS_SIZE (localparam), DATA_SIZE+ADDR_SIZE+1. Flit layout: [ADDR_SIZE-1:0] destination address, [ADDR_SIZE] tail flag, [BUS_SIZE-1:ADDR_SIZE+1] payload.

Ports:
- clk  input  1  system clock, rising edge.
- a_rst_n  input  1  asynchronous active-low reset.
- req_i  input  PORTS_NUM+1  per-port request (FIFO non-empty, head flit routed to this output).
- data_i  input  (PORTS_NUM+1)*BUS_SIZE  flattened head flits; port p occupies [p*BUS_SIZE +: BUS_SIZE].
- out_full_i  input  1  downstream almost-full (at least one spare entry guaranteed while high).
- rd_o  output  PORTS_NUM+1  one-hot pop strobe to the input FIFOs (combinational).
- out_wr_o  output  1  registered write strobe to the output link.
- out_data_o  output  BUS_SIZE  registered flit.
- grant_o  output  PORTS_NUM+1  registered one-hot current grant; all zeros when idle.
- err_o  output  1  registered watchdog error pulse.

Behaviour:
- Reset (a_rst_n low, asynchronous):
  - state = IDLE.
  - rd_o, out_wr_o, grant_o, err_o = 0.
  - out_data_o = 0.
  - last_grant = PORTS_NUM, so the first search starts at port 0.
- Reset mid-packet: the lock and any partial packet are abandoned. Nothing is popped during reset.
- FSM states:
  - IDLE:
    - If req_i is nonzero, select the first set bit searching from last_grant+1 upward, wrapping modulo PORTS_NUM+1.
    - Register the choice into grant_o and move to BUSY.
    - No pop occurs in IDLE.
    - If req_i is 0, stay in IDLE.
  - BUSY (grant g):
    - Transfer condition: xfer = req_i[g] & !out_full_i.
    - On xfer:
      - rd_o[g] = 1 in the same cycle.
      - Next edge: out_data_o <= data_i[g], out_wr_o <= 1.
    - Without xfer:
      - rd_o = 0.
      - Next edge: out_wr_o <= 0; out_data_o holds its value.
    - Tail handling: on an xfer whose flit has bit ADDR_SIZE set, next state = IDLE, last_grant <= g, grant_o <= 0.
- Latency and throughput:
  - One cycle from pop to out_wr_o.
  - Throughput is one flit per cycle inside a packet.
  - There is exactly one idle (re-arbitration) cycle between consecutive packets.
- Holds inside BUSY:
  - req_i[g] dropping mid-packet holds the lock; other ports' requests are ignored.
  - out_full_i high stalls: no pop, lock held.
- Single-flit packets (tail set on the first flit) are legal: IDLE → BUSY → IDLE.
- Fairness: a port granted last has the lowest priority at the next arbitration. A requesting port waits at most PORTS_NUM packets.
- At most one bit of rd_o is ever set. rd_o is never set in IDLE or during reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter increments each BUSY cycle with req_i[g] = 0.
  - The counter clears on any xfer and on entry to BUSY.
  - When it reaches 2^TIMEOUT_W-1:
    - err_o pulses high for one cycle.
    - State goes to IDLE; grant_o is cleared.
    - last_grant <= g; the abandoned packet is not flushed.
  - out_full_i stalls do not count toward the timeout.
- Not defined: no counter exists; err_o is tied to 0; the lock is held indefinitely.

Test Plan:
- Reset then a single request: req_i = 5'b00100, data_i[2] = flit with tail = 1, addr = 4'h3, payload 32'hA5A5A5A5. Expected: grant_o = 5'b00100 one cycle after the request; rd_o[2] pulses in the next cycle; out_wr_o = 1 with out_data_o = that flit one cycle later; then back to IDLE.
- Round-robin: all five ports request continuously, each sending 2-flit packets. Expected: grant order 0,1,2,3,4,0; each packet is 2 writes followed by 1 idle cycle; rd_o is always one-hot.
- Back-pressure: port 1 sends a 3-flit packet; out_full_i is high for 4 cycles after the first flit. Expected: no rd_o and no out_wr_o during those cycles; grant_o stays 5'b00010; the remaining 2 flits are sent in order after release.
- Lock hold: port 0 mid-packet drops req_i[0] for 5 cycles while port 3 requests. Expected: port 3 is not granted until port 0's tail is transferred.
- Mid-packet reset: assert a_rst_n = 0 during flit 2 of 4. Expected: all outputs go to 0 immediately. After release with only port 0 requesting, the grant goes to port 0 (last_grant = PORTS_NUM).
- With ARB_TIMEOUT_EN and TIMEOUT_W = 3: the granted port stalls its requests for 7 cycles. Expected: err_o pulses once, grant_o = 0, and the next request is arbitrated normally.
